// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- load/store initiator for the data-memory responder.
//
// Forms the effective address from rsd + imm, checks alignment, and runs
// one word-addressed req/ack transaction with byte enables. Load data is
// taken from the addressed lane and sign- or zero-extended onto wtd.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             pulse that begins an access (only honoured in IDLE)
//   we, size, sext    store/load, access size (00 B, 01 H, 10 W, 11 bad), sign-ext
//   rsd, imm, rtd     base address, signed offset, store data
//   busy, done, err   busy from accepted start through the one-cycle done pulse;
//                     err qualifies done (misaligned, reserved size, timeout)
//   wtd               load result, updated on done, held between accesses
//   mem_req/we/addr/be/wdata   request side of the data-memory port
//   mem_rdata/ack              response side of the data-memory port
// -----------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       rsd,
  input  logic [31:0]       imm,
  input  logic [31:0]       rtd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       wtd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Wide enough to hold TIMEOUT-1 even when TIMEOUT is 1.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic              we_q;
  logic              sext_q;
  logic [1:0]        size_q;
  logic [31:0]       ea_q;
  logic [31:0]       rtd_q;
  logic [31:0]       wtd_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt;

  logic [31:0]       ea;
  logic              misaligned;
  logic              timeout_hit;
  logic [31:0]       load_data;
  logic [3:0]        be_w;
  logic [31:0]       wdata_w;

  // Effective address wraps modulo 2^32 by construction.
  assign ea = rsd + imm;

  // NOTE: every signal assigned in an always_comb gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    misaligned = 1'b1;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = ea[0];
      SZ_WORD: misaligned = |ea[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // cnt counts REQ cycles already spent without ack; the TIMEOUT-th REQ
  // cycle is the last one.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = misaligned ? DONE : REQ;
      REQ:  if (mem_ack || timeout_hit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Lane extraction: byte and half select by ea_q, word passes through.
  always_comb begin
    load_data = mem_rdata;
    case (size_q)
      SZ_BYTE: load_data = {{24{sext_q & mem_rdata[{ea_q[1:0], 3'b000} + 7]}},
                            mem_rdata[{ea_q[1:0], 3'b000} +: 8]};
      SZ_HALF: load_data = {{16{sext_q & mem_rdata[{ea_q[1], 4'b0000} + 15]}},
                            mem_rdata[{ea_q[1], 4'b0000} +: 16]};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      sext_q <= 1'b0;
      size_q <= 2'b00;
      ea_q   <= '0;
      rtd_q  <= '0;
      wtd_q  <= '0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            we_q   <= we;
            sext_q <= sext;
            size_q <= size;
            ea_q   <= ea;
            rtd_q  <= rtd;
            cnt    <= '0;
            err_q  <= misaligned;
            // A rejected access completes next cycle with a zero result.
            if (misaligned) wtd_q <= '0;
          end
        end
        REQ: begin
          // An ack on the final REQ cycle still wins over the timeout.
          if (mem_ack) begin
            wtd_q <= we_q ? 32'h0 : load_data;
            err_q <= 1'b0;
          end else if (timeout_hit) begin
            wtd_q <= '0;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    be_w    = 4'b0000;
    wdata_w = rtd_q;
    case (size_q)
      SZ_BYTE: begin
        be_w    = 4'b0001 << ea_q[1:0];
        wdata_w = {4{rtd_q[7:0]}};
      end
      SZ_HALF: begin
        be_w    = ea_q[1] ? 4'b1100 : 4'b0011;
        wdata_w = {2{rtd_q[15:0]}};
      end
      SZ_WORD: begin
        be_w    = 4'b1111;
        wdata_w = rtd_q;
      end
      default: ;
    endcase
  end

  // The memory port is driven only in REQ; it reads as all-zero otherwise.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = done & err_q;
  assign wtd       = wtd_q;
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? ea_q[ADDR_W+1:2] : '0;
  assign mem_be    = mem_req ? be_w : 4'b0000;
  assign mem_wdata = mem_req ? wdata_w : 32'h0;

endmodule
